zbuffer_pixel_sink: RTL and testbench



---
 rtl/zbuffer_pixel_sink.sv | 173 +++++++++++++++++
 tb/tb_zbuffer_pixel_sink.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/zbuffer_pixel_sink.sv
// Depth-tested pixel sink with depth RAM, clear FSM and registered framebuffer writes.
// Optional per-frame pixel counters are enabled with ZSINK_STATS_EN.
module zbuffer_pixel_sink #(
  parameter int FB_HRES = 320,
  parameter int FB_VRES = 180,
  parameter int Z_WIDTH = 20,
  parameter int COLOR_WIDTH = 16,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = 16'h0000,
  localparam int DEPTH = FB_HRES * FB_VRES,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [ADDR_WIDTH-1:0]  addr_in,
  input  logic [Z_WIDTH-1:0]     z_in,
  input  logic [COLOR_WIDTH-1:0] color_in,
  input  logic                   last_pixel_in,
  input  logic                   last_tri_in,
  input  logic                   clear_start_in,
  output logic                   fb_we_out,
  output logic [ADDR_WIDTH-1:0]  fb_addr_out,
  output logic [COLOR_WIDTH-1:0] fb_data_out,
  output logic                   busy_out,
  output logic                   frame_done_out,
  output logic [31:0]            pix_in_count_out,
  output logic [31:0]            pix_wr_count_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic                   done_d, done_q;

  logic                   s1_v_q;
  logic [ADDR_WIDTH-1:0]  s1_addr_q;
  logic [Z_WIDTH-1:0]     s1_z_q;
  logic [COLOR_WIDTH-1:0] s1_color_q;

  logic                   byp_v_q;
  logic [ADDR_WIDTH-1:0]  byp_addr_q;
  logic [Z_WIDTH-1:0]     byp_z_q;

  logic [Z_WIDTH-1:0]     ram [DEPTH];
  logic [Z_WIDTH-1:0]     rd_q;
  logic [Z_WIDTH-1:0]     ref_z;

  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  waddr_q;
  logic [COLOR_WIDTH-1:0] wdata_q;

  logic accept, pass, clr_wr;

  assign accept = (state_q == RUN) && valid_in;
  assign clr_wr = (state_q == CLEAR);
  assign ref_z  = (byp_v_q && byp_addr_q == s1_addr_q) ? byp_z_q : rd_q;
  assign pass   = s1_v_q && (s1_z_q < ref_z);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_start_in) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = RUN;
      end
      RUN: begin
        if (accept && last_pixel_in && last_tri_in) state_d = DRAIN;
      end
      DRAIN: begin
        if (!s1_v_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_addr_q  <= '0;
      s1_z_q     <= '0;
      s1_color_q <= '0;
      byp_v_q    <= 1'b0;
      byp_addr_q <= '0;
      byp_z_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      s1_v_q  <= accept;
      if (accept) begin
        s1_addr_q  <= addr_in;
        s1_z_q     <= z_in;
        s1_color_q <= color_in;
      end
      byp_v_q <= pass;
      if (pass) begin
        byp_addr_q <= s1_addr_q;
        byp_z_q    <= s1_z_q;
      end
      we_q <= clr_wr || pass;
      if (clr_wr) begin
        waddr_q <= cnt_q;
        wdata_q <= CLEAR_COLOR;
      end else if (pass) begin
        waddr_q <= s1_addr_q;
        wdata_q <= s1_color_q;
      end
    end
  end

  // Read-first RAM; contents survive reset, writes are suppressed during it.
  always_ff @(posedge clk_in) begin
    rd_q <= ram[addr_in];
    if (!rst_in) begin
      if (clr_wr) ram[cnt_q] <= '1;
      else if (pass) ram[s1_addr_q] <= s1_z_q;
    end
  end

  assign ready_out      = (state_q == RUN);
  assign busy_out       = (state_q != IDLE);
  assign frame_done_out = done_q;
  assign fb_we_out      = we_q;
  assign fb_addr_out    = waddr_q;
  assign fb_data_out    = wdata_q;

`ifdef ZSINK_STATS_EN
  logic [31:0] in_cnt_q, wr_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in || (state_q == IDLE && clear_start_in)) begin
      in_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (accept && in_cnt_q != '1) in_cnt_q <= in_cnt_q + 1'b1;
      if (pass && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  assign pix_in_count_out = in_cnt_q;
  assign pix_wr_count_out = wr_cnt_q;
`else
  assign pix_in_count_out = '0;
  assign pix_wr_count_out = '0;
`endif

endmodule

// File: tb/tb_zbuffer_pixel_sink.sv
// Directed bench for zbuffer_pixel_sink on a 4x2 framebuffer.
// Vector table covers depth test and bypass; hand sequences cover clear, frame end, reset.
module tb_zbuffer_pixel_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [2:0]  addr = '0;
  logic [19:0] z = '0;
  logic [15:0] color = '0;
  logic        lastp = 1'b0;
  logic        lastt = 1'b0;
  logic        clr = 1'b0;
  logic        fb_we;
  logic [2:0]  fb_addr;
  logic [15:0] fb_data;
  logic        busy;
  logic        done;
  logic [31:0] in_cnt;
  logic [31:0] wr_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  zbuffer_pixel_sink #(
    .FB_HRES(4),
    .FB_VRES(2)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .valid_in(valid),
    .ready_out(ready),
    .addr_in(addr),
    .z_in(z),
    .color_in(color),
    .last_pixel_in(lastp),
    .last_tri_in(lastt),
    .clear_start_in(clr),
    .fb_we_out(fb_we),
    .fb_addr_out(fb_addr),
    .fb_data_out(fb_data),
    .busy_out(busy),
    .frame_done_out(done),
    .pix_in_count_out(in_cnt),
    .pix_wr_count_out(wr_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected fb fields describe the write produced by the previous row's pixel.
  typedef struct {
    logic        v;
    logic [2:0]  a;
    logic [19:0] z;
    logic [15:0] c;
    logic        we;
    logic [2:0]  ea;
    logic [15:0] ed;
  } vec_t;

  function automatic vec_t mk(logic v, logic [2:0] a, logic [19:0] zz,
                              logic [15:0] c, logic we, logic [2:0] ea,
                              logic [15:0] ed);
    vec_t r;
    r.v = v; r.a = a; r.z = zz; r.c = c;
    r.we = we; r.ea = ea; r.ed = ed;
    return r;
  endfunction

  vec_t tbl [19];

  initial begin
    tbl[0]  = mk(1, 3, 100, 16'hF800, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,   16'h0000, 1, 3, 16'hF800);
    tbl[2]  = mk(1, 3, 200, 16'h07E0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,   16'h0000, 0, 0, 0);
    tbl[4]  = mk(1, 3, 100, 16'h1234, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0,   16'h0000, 0, 0, 0);
    tbl[6]  = mk(1, 5, 50,  16'h001F, 0, 0, 0);
    tbl[7]  = mk(1, 5, 60,  16'hAAAA, 1, 5, 16'h001F);
    tbl[8]  = mk(0, 0, 0,   16'h0000, 0, 0, 0);
    tbl[9]  = mk(1, 6, 60,  16'h1111, 0, 0, 0);
    tbl[10] = mk(1, 6, 50,  16'hFFFF, 1, 6, 16'h1111);
    tbl[11] = mk(0, 0, 0,   16'h0000, 1, 6, 16'hFFFF);
    tbl[12] = mk(1, 6, 55,  16'h2222, 0, 0, 0);
    tbl[13] = mk(0, 0, 0,   16'h0000, 0, 0, 0);
    tbl[14] = mk(1, 0, 7,   16'h0A0A, 0, 0, 0);
    tbl[15] = mk(1, 1, 9,   16'h0B0B, 1, 0, 16'h0A0A);
    tbl[16] = mk(1, 0, 6,   16'h0C0C, 1, 1, 16'h0B0B);
    tbl[17] = mk(0, 0, 0,   16'h0000, 1, 0, 16'h0C0C);
    tbl[18] = mk(0, 0, 0,   16'h0000, 0, 0, 0);

    // Reset state
    @(negedge clk);
    cyc();
    chk("rst_ready", ready, 0);
    chk("rst_we", fb_we, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", fb_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    cyc();
    chk("idle_busy", busy, 0);

    // Clear: 8 writes of CLEAR_COLOR, ready rises with the last one
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_busy", busy, 1);
    chk("clr_ready0", ready, 0);
    chk("clr_we0", fb_we, 0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("clr_we", fb_we, 1);
      chk("clr_addr", fb_addr, 64'(k));
      chk("clr_data", fb_data, 0);
      chk("clr_ready", ready, (k == 7) ? 1 : 0);
    end

    // Depth test and bypass vectors
    for (int i = 0; i < 19; i++) begin
      valid = tbl[i].v;
      addr  = tbl[i].a;
      z     = tbl[i].z;
      color = tbl[i].c;
      cyc();
      chk($sformatf("vec%0d_we", i), fb_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("vec%0d_addr", i), fb_addr, tbl[i].ea);
        chk($sformatf("vec%0d_data", i), fb_data, tbl[i].ed);
      end
      chk($sformatf("vec%0d_ready", i), ready, 1);
    end

    // End of frame
    valid = 1'b1; addr = 3'd2; z = 20'd1; color = 16'h3333;
    lastp = 1'b1; lastt = 1'b1;
    cyc();
    valid = 1'b0; lastp = 1'b0; lastt = 1'b0;
    chk("eof_ready", ready, 0);
    chk("eof_busy1", busy, 1);
    chk("eof_done0", done, 0);
    cyc();
    chk("eof_we", fb_we, 1);
    chk("eof_addr", fb_addr, 2);
    chk("eof_data", fb_data, 16'h3333);
    chk("eof_done1", done, 0);
    cyc();
    chk("eof_done", done, 1);
    chk("eof_busy", busy, 0);
    chk("eof_we_off", fb_we, 0);
`ifdef ZSINK_STATS_EN
    chk("stat_in", in_cnt, 12);
    chk("stat_wr", wr_cnt, 8);
`endif
    // valid while idle must be ignored; done must not repeat
    valid = 1'b1; addr = 3'd4; z = 20'd0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("idle_done", done, 0);
      chk("idle_we", fb_we, 0);
      chk("idle_ready", ready, 0);
    end
    valid = 1'b0;

    // Reset during clear cycle 3
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("mid_we", fb_we, 1);
    chk("mid_addr", fb_addr, 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_we", fb_we, 0);
    chk("mrst_addr", fb_addr, 0);
    chk("mrst_data", fb_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", ready, 0);
    chk("mrst_done", done, 0);
`ifdef ZSINK_STATS_EN
    chk("mrst_in", in_cnt, 0);
    chk("mrst_wr", wr_cnt, 0);
`endif
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("post_we", fb_we, 0);
      chk("post_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
